io_peripheral_ctrl: RTL and testbench
=====================================

IO_PERIPHERAL_CTRL -- requirements
Module: io_peripheral_ctrl

Interface
REQ-001 Parameter N, default 8, bus data/address width in bits.
REQ-002 Parameter DEB_CYCLES, default 250000, stable clk cycles required to accept a new button level.
REQ-003 Parameter SCAN_DIV, default 50000, clk cycles each display digit stays enabled.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 Addr  input  N  processor bus address, compared as unsigned bit pattern.
REQ-007 WE  input  1  processor bus write enable.
REQ-008 WriteData  input  N  processor bus write data, signed two's complement.
REQ-009 BtnRaw  input  1  raw asynchronous push-button, active-high.
REQ-010 SwRaw  input  N  raw asynchronous switches.
REQ-011 ReadP2  output  1  debounced button level toward data memory read port 254.
REQ-012 ReadP3  output  N  synchronized switch value toward data memory read port 255.
REQ-013 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-014 an  output  4  digit enables, active-low one-hot; an[3] sign, an[2] hundreds, an[1] tens, an[0] units.

Function
REQ-015 Display capture: on rising clk with WE=1 and Addr=253, WriteData SHALL be loaded into the display register; no other address or WE=0 leaves it unchanged.
REQ-016 Capture SHALL start conversion: FSM IDLE -> CONV (exactly N cycles, one double-dabble shift per cycle on |value|) -> LOAD (1 cycle) -> IDLE.
REQ-017 Magnitude SHALL be computed in N+1 bits so -128 converts to 128; sign flag = MSB of captured value.
REQ-018 Shown digits (sign flag + 3 BCD digits) SHALL update only in LOAD; capture-to-shown latency is N+1 cycles (9 for N=8).
REQ-019 A capture during CONV or LOAD SHALL restart CONV with the new value; the abandoned value is never shown.
REQ-020 Scan counter SHALL advance digit index 3->2->1->0->3 every SCAN_DIV cycles, wrapping; exactly one an bit low at all times after reset.
REQ-021 Sign digit: '-' (only g lit, seg=0111111) when negative, blank (seg=1111111) otherwise.
REQ-022 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens both 0; units always shown.
REQ-023 Digit decode 0-9 SHALL use standard active-low patterns (0=1000000, 1=1111001, ... 9=0010000).
REQ-024 Button: BtnRaw SHALL pass a 2-flop synchronizer; ReadP2 changes only after the synchronized level differs from ReadP2 for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-025 Switches: SwRaw SHALL pass a 2-flop synchronizer per bit; ReadP3 equals SwRaw delayed 2 cycles, no debounce.
REQ-026 Bus reads (WE=0) SHALL have no effect on any state.

Reset
REQ-027 rst=1 SHALL immediately, without clk, force: display register 0, FSM IDLE, shown digits 0/positive, scan index 3, an=0111, seg=1111111, debounce counter 0, ReadP2=0, synchronizers 0, ReadP3=0.
REQ-028 After rst release, an=1110 with seg=1000000 ("0") SHALL appear when the scan reaches units; rst mid-CONV SHALL abandon the conversion and show 0.

Verification
REQ-029 Write 8'd123 to Addr 253 -> 9 cycles later digits blank/1/2/3; cycle 8 still shows old value.
REQ-030 Write 8'h80 (-128) -> '-'/1/2/8; write 8'hF9 (-7) -> '-'/blank/blank/7; write 0 -> blank/blank/blank/0.
REQ-031 Write 42 then write 99 three cycles later -> 42 never shown, 99 shown 9 cycles after second write; write to Addr 252 or with WE=0 -> no change.
REQ-032 BtnRaw bouncing with pulses shorter than DEB_CYCLES (DEB_CYCLES=8 in bench) -> ReadP2 stays 0; held high 8+2 cycles -> ReadP2=1.
REQ-033 SwRaw=8'hA5 -> ReadP3=8'hA5 exactly 2 cycles later; with SCAN_DIV=4, an sequence 0111,1011,1101,1110 repeating every 16 cycles.
REQ-034 Assert rst asynchronously mid-CONV and mid-debounce -> all outputs at REQ-027 values before next clk edge.

Source files
------------

// File: rtl/io_peripheral_ctrl.sv
// Memory-mapped I/O block: signed display register with serial binary-to-BCD conversion,
// multiplexed 4-digit 7-segment scan, debounced push-button and synchronized switches.
module io_peripheral_ctrl #(
  parameter int N          = 8,
  parameter int DEB_CYCLES = 250000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Addr,
  input  logic         WE,
  input  logic [N-1:0] WriteData,
  input  logic         BtnRaw,
  input  logic [N-1:0] SwRaw,
  output logic         ReadP2,
  output logic [N-1:0] ReadP3,
  output logic [6:0]   seg,
  output logic [3:0]   an
);

  localparam logic [N-1:0] DISP_ADDR = N'(253);
  localparam int CW  = $clog2(N + 1);
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam int SW  = $clog2(SCAN_DIV + 1);
  localparam int SRW = 12 + N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   disp_q, disp_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [SRW-1:0] sr_adj;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [3:0]     hun_q, hun_d;
  logic [3:0]     ten_q, ten_d;
  logic [3:0]     one_q, one_d;
  logic [N:0]     wd_ext;
  logic [N:0]     mag;
  logic           capture;

  logic [SW-1:0]  scan_q;
  logic [1:0]     idx_q;

  logic           btn_s1_q, btn_s2_q;
  logic [DW-1:0]  deb_q;
  logic           p2_q;
  logic [N-1:0]   sw_s1_q, sw_s2_q;

  assign capture = WE && (Addr == DISP_ADDR);

  // Magnitude carries one extra bit so the most negative value converts correctly.
  assign wd_ext = {WriteData[N-1], WriteData};
  assign mag    = WriteData[N-1] ? (~wd_ext + (N+1)'(1)) : wd_ext;

  // Double-dabble add-3 correction on each BCD nibble before the shift.
  assign sr_adj[N-1:0] = sr_q[N-1:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign sr_adj[N+4*gi +: 4] = (sr_q[N+4*gi +: 4] >= 4'd5) ? (sr_q[N+4*gi +: 4] + 4'd3)
                                                              : sr_q[N+4*gi +: 4];
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    if (capture) begin
      // A new capture always wins, abandoning any conversion in flight.
      disp_d  = WriteData;
      sr_d    = {11'd0, mag};
      cnt_d   = '0;
      state_d = S_CONV;
    end else begin
      case (state_q)
        S_CONV: begin
          sr_d  = sr_adj << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          sign_d  = disp_q[N-1];
          hun_d   = sr_q[N+8 +: 4];
          ten_d   = sr_q[N+4 +: 4];
          one_d   = sr_q[N +: 4];
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      disp_q  <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      hun_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
    end
  end

  // Digit scan: sign, hundreds, tens, units, each held for SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= 2'd3;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_q - 2'd1;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  // Any sample that agrees with the current level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      deb_q    <= '0;
      p2_q     <= 1'b0;
    end else begin
      btn_s1_q <= BtnRaw;
      btn_s2_q <= btn_s1_q;
      if (btn_s2_q != p2_q) begin
        if (deb_q == DW'(DEB_CYCLES - 1)) begin
          p2_q  <= btn_s2_q;
          deb_q <= '0;
        end else begin
          deb_q <= deb_q + DW'(1);
        end
      end else begin
        deb_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SwRaw;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign ReadP2 = p2_q;
  assign ReadP3 = sw_s2_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Leading zeros of hundreds and tens are blanked; units always lit.
  always_comb begin
    an  = ~(4'b0001 << idx_q);
    seg = 7'b1111111;
    case (idx_q)
      2'd3: seg = sign_q ? 7'b0111111 : 7'b1111111;
      2'd2: if (hun_q != 4'd0) seg = seg7(hun_q);
      2'd1: if ((hun_q != 4'd0) || (ten_q != 4'd0)) seg = seg7(ten_q);
      default: seg = seg7(one_q);
    endcase
  end

endmodule

// File: tb/tb_io_peripheral_ctrl.sv
// Randomized scoreboard bench for io_peripheral_ctrl: writes queue expected display values,
// a negedge monitor compares scan/segment/button/switch outputs against a reference model.
module tb_io_peripheral_ctrl;

  localparam int N    = 8;
  localparam int DEB  = 8;
  localparam int SCAN = 4;
  localparam int LAT  = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Addr = 8'd0;
  logic       WE = 1'b0;
  logic [7:0] WriteData = 8'd0;
  logic       BtnRaw = 1'b0;
  logic [7:0] SwRaw = 8'd0;
  logic       ReadP2;
  logic [7:0] ReadP3;
  logic [6:0] seg;
  logic [3:0] an;

  io_peripheral_ctrl #(.N(N), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WE(WE), .WriteData(WriteData),
    .BtnRaw(BtnRaw), .SwRaw(SwRaw), .ReadP2(ReadP2), .ReadP3(ReadP3),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         due;
  } disp_t;

  disp_t      pend_q[$];
  logic       hist[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         since_flip = 0;
  logic [7:0] shown = 8'd0;
  logic       b1 = 1'b0, b2 = 1'b0, exp_p2 = 1'b0;
  logic [7:0] sw1 = 8'd0, exp_p3 = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] digit(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segment pattern for a decimal rendering of a signed value at a given digit slot.
  function automatic logic [6:0] exp_seg_of(input int idx, input logic [7:0] v);
    int sv, mag, h, t, u;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    case (idx)
      3: return (sv < 0) ? 7'b0111111 : 7'b1111111;
      2: return (h != 0) ? digit(h) : 7'b1111111;
      1: return ((h != 0) || (t != 0)) ? digit(t) : 7'b1111111;
      default: return digit(u);
    endcase
  endfunction

  // Reference model: edge count, input histories and debounced level.
  always @(posedge clk) begin
    logic s, all_diff;
    if (rst) begin
      cyc = 0; shown = 8'd0; pend_q.delete(); hist.delete();
      b1 = 1'b0; b2 = 1'b0; exp_p2 = 1'b0; since_flip = 0;
      sw1 = 8'd0; exp_p3 = 8'd0;
    end else begin
      cyc++;
      exp_p3 = sw1;
      sw1 = SwRaw;
      s = b2; b2 = b1; b1 = BtnRaw;
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      since_flip++;
      if (since_flip >= DEB && hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == exp_p2) all_diff = 1'b0;
        if (all_diff) begin
          exp_p2 = ~exp_p2;
          since_flip = 0;
        end
      end
    end
  end

  // Monitor: retire due display values, then compare every visible output.
  always @(negedge clk) begin
    int         exp_idx;
    logic [3:0] exp_an;
    if (!rst) begin
      while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        shown = pend_q[0].val;
        void'(pend_q.pop_front());
      end
      exp_idx = 3 - ((cyc / SCAN) % 4);
      exp_an = 4'b1111;
      exp_an[exp_idx] = 1'b0;
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg_of(exp_idx, shown)));
      chk("ReadP2", 32'(ReadP2), 32'(exp_p2));
      chk("ReadP3", 32'(ReadP3), 32'(exp_p3));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] a, input logic we, input logic [7:0] d);
    disp_t e;
    @(negedge clk);
    Addr = a; WE = we; WriteData = d;
    $display("bus addr=%0d we=%0b data=%0h cycle=%0d", a, we, d, cyc);
    if (we && a == 8'd253) begin
      if (pend_q.size() > 0 && pend_q[$].due >= cyc + 1) void'(pend_q.pop_back());
      e.val = d;
      e.due = cyc + 1 + LAT;
      pend_q.push_back(e);
    end
    @(negedge clk);
    WE = 1'b0; Addr = 8'($urandom); WriteData = 8'($urandom);
  endtask

  task automatic btn_run(input logic lvl, input int n);
    @(negedge clk);
    BtnRaw = lvl;
    idle(n - 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'(4'b0111));
    chk("rst_seg", 32'(seg), 32'(7'b1111111));
    chk("rst_p2", 32'(ReadP2), 32'(1'b0));
    chk("rst_p3", 32'(ReadP3), 32'(8'h00));
    #1 rst = 1'b0;
    idle(20);

    bus(8'd253, 1'b1, 8'd123);  idle(20);
    bus(8'd253, 1'b1, 8'h80);   idle(20);
    bus(8'd253, 1'b1, 8'hF9);   idle(20);
    bus(8'd253, 1'b1, 8'd0);    idle(20);
    bus(8'd253, 1'b1, 8'd42);   idle(1);
    bus(8'd253, 1'b1, 8'd99);   idle(20);
    bus(8'd253, 1'b1, 8'd5);    idle(7);
    bus(8'd253, 1'b1, 8'd6);    idle(20);
    bus(8'd252, 1'b1, 8'd77);   idle(20);
    bus(8'd253, 1'b0, 8'd77);   idle(20);

    // Switch path latency.
    @(negedge clk); SwRaw = 8'hA5;
    @(negedge clk); chk("sw_1cyc", 32'(ReadP3), 32'(8'h00));
    @(negedge clk); chk("sw_2cyc", 32'(ReadP3), 32'(8'hA5));

    // Bounces shorter than the debounce window, then a clean hold.
    btn_run(1'b1, 5); btn_run(1'b0, 2); btn_run(1'b1, 4); btn_run(1'b0, 3);
    btn_run(1'b1, 6); btn_run(1'b0, 10);
    chk("btn_bounce", 32'(ReadP2), 32'(1'b0));
    btn_run(1'b1, 11);
    chk("btn_hold", 32'(ReadP2), 32'(1'b1));
    btn_run(1'b0, 11);
    chk("btn_release", 32'(ReadP2), 32'(1'b0));

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int kind;
          kind = int'($urandom_range(0, 3));
          case (kind)
            0, 1: bus(8'd253, 1'b1, 8'($urandom));
            2:    bus(8'd252, 1'b1, 8'($urandom));
            default: bus(8'd253, 1'b0, 8'($urandom));
          endcase
          idle(int'($urandom_range(0, 12)));
        end
      end
      begin
        repeat (400) begin
          @(negedge clk);
          if ($urandom_range(0, 5) == 0) BtnRaw = ~BtnRaw;
          SwRaw = 8'($urandom);
        end
      end
    join

    // Async reset mid-conversion and mid-debounce.
    btn_run(1'b1, 12);
    chk("btn_pre_rst", 32'(ReadP2), 32'(1'b1));
    @(negedge clk); BtnRaw = 1'b0; SwRaw = 8'h3C;
    bus(8'd253, 1'b1, 8'd77);
    idle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'(4'b0111));
    chk("arst_seg", 32'(seg), 32'(7'b1111111));
    chk("arst_p2", 32'(ReadP2), 32'(1'b0));
    chk("arst_p3", 32'(ReadP3), 32'(8'h00));
    @(posedge clk);
    #2 rst = 1'b0;
    SwRaw = 8'h00;
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
